// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter: source-select encoding,
// the packed queue entry and the register-write qualification helper.
package wb_arbiter_pkg;

    localparam logic [1:0] WB_SRC_IP  = 2'b01;
    localparam logic [1:0] WB_SRC_LP  = 2'b10;
    localparam int         WB_ENTRY_W = 5 + 64 + 64 + 1;

    typedef struct packed {
        logic [4:0]  dst;
        logic [63:0] result;
        logic [63:0] pc;
        logic        wb_en;
    } wb_entry_t;

    // Writes to x0 are architecturally discarded, so they never reach the file.
    function automatic logic wb_writes_rf(input wb_entry_t entry);
        return entry.wb_en && (entry.dst != 5'd0);
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle for the writeback arbiter: two producer beats in, register-file
// write port and retire strobe out.
interface wb_arbiter_if;

    logic [4:0]  ip_wb_dst;
    logic [63:0] ip_wb_result;
    logic [63:0] ip_wb_pc;
    logic        ip_wb_wb_en;
    logic        ip_wb_valid;
    logic        ip_wb_ready;

    logic [4:0]  lp_wb_dst;
    logic [63:0] lp_wb_result;
    logic [63:0] lp_wb_pc;
    logic        lp_wb_wb_en;
    logic        lp_wb_valid;
    logic        lp_wb_ready;

    logic        wb_rf_wr_en;
    logic [4:0]  wb_rf_wr_addr;
    logic [63:0] wb_rf_wr_data;
    logic        wb_retire_valid;
    logic [63:0] wb_retire_pc;
    logic [63:0] wb_retire_cnt;

    modport master (
        output ip_wb_dst, ip_wb_result, ip_wb_pc, ip_wb_wb_en, ip_wb_valid,
        input  ip_wb_ready,
        output lp_wb_dst, lp_wb_result, lp_wb_pc, lp_wb_wb_en, lp_wb_valid,
        input  lp_wb_ready,
        input  wb_rf_wr_en, wb_rf_wr_addr, wb_rf_wr_data,
        input  wb_retire_valid, wb_retire_pc, wb_retire_cnt
    );

    modport slave (
        input  ip_wb_dst, ip_wb_result, ip_wb_pc, ip_wb_wb_en, ip_wb_valid,
        output ip_wb_ready,
        input  lp_wb_dst, lp_wb_result, lp_wb_pc, lp_wb_wb_en, lp_wb_valid,
        output lp_wb_ready,
        output wb_rf_wr_en, wb_rf_wr_addr, wb_rf_wr_data,
        output wb_retire_valid, wb_retire_pc, wb_retire_cnt
    );

endinterface

// File: rtl/wb_arbiter_fifo.sv
// wb_fifo: small synchronous FIFO, power-of-two depth, with registered occupancy
// so full/empty never depend combinationally on push/pop.
module wb_fifo #(
    parameter int WIDTH = 134,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign head      = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Entry storage; payload needs no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: queues integer and load/store results, retires one per cycle
// round-robin. Define WB_ARBITER_RETIRE_CNT_EN to build the retired-instruction counter.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);

    wb_entry_t        ip_in_s;
    wb_entry_t        lp_in_s;
    wb_entry_t        ip_head_s;
    wb_entry_t        lp_head_s;
    wb_entry_t        sel_s;
    logic             ip_full_s;
    logic             ip_empty_s;
    logic             lp_full_s;
    logic             lp_empty_s;
    logic             ip_push_s;
    logic             lp_push_s;
    logic             ip_pop_s;
    logic             lp_pop_s;
    logic             pop_any_s;
    logic [1:0]       last_grant_r;

    logic             rf_wr_en_r;
    logic [4:0]       rf_wr_addr_r;
    logic [63:0]      rf_wr_data_r;
    logic             retire_valid_r;
    logic [63:0]      retire_pc_r;

    assign ip_in_s   = '{dst: bus.ip_wb_dst, result: bus.ip_wb_result,
                         pc: bus.ip_wb_pc, wb_en: bus.ip_wb_wb_en};
    assign lp_in_s   = '{dst: bus.lp_wb_dst, result: bus.lp_wb_result,
                         pc: bus.lp_wb_pc, wb_en: bus.lp_wb_wb_en};

    assign bus.ip_wb_ready = !ip_full_s;
    assign bus.lp_wb_ready = !lp_full_s;
    assign ip_push_s       = bus.ip_wb_valid && !ip_full_s;
    assign lp_push_s       = bus.lp_wb_valid && !lp_full_s;

    wb_fifo #(.WIDTH(WB_ENTRY_W), .DEPTH(FIFO_DEPTH)) u_ip_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ip_push_s),
        .pop   (ip_pop_s),
        .din   (ip_in_s),
        .full  (ip_full_s),
        .empty (ip_empty_s),
        .head  (ip_head_s)
    );

    wb_fifo #(.WIDTH(WB_ENTRY_W), .DEPTH(FIFO_DEPTH)) u_lp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (lp_push_s),
        .pop   (lp_pop_s),
        .din   (lp_in_s),
        .full  (lp_full_s),
        .empty (lp_empty_s),
        .head  (lp_head_s)
    );

    // Round-robin grant: ip wins a tie only when lp was granted last.
    always_comb begin
        ip_pop_s = 1'b0;
        lp_pop_s = 1'b0;
        if (!ip_empty_s && (lp_empty_s || (last_grant_r == WB_SRC_LP))) begin
            ip_pop_s = 1'b1;
        end else if (!lp_empty_s) begin
            lp_pop_s = 1'b1;
        end else begin
            ip_pop_s = 1'b0;
            lp_pop_s = 1'b0;
        end
    end

    assign pop_any_s = ip_pop_s || lp_pop_s;
    assign sel_s     = ip_pop_s ? ip_head_s : lp_head_s;

    // Last-grant pointer only moves when something is actually popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= WB_SRC_LP;
        end else if (ip_pop_s) begin
            last_grant_r <= WB_SRC_IP;
        end else if (lp_pop_s) begin
            last_grant_r <= WB_SRC_LP;
        end
    end

    // Registered write/retire port; addr/data hold between retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wr_en_r     <= 1'b0;
            rf_wr_addr_r   <= 5'd0;
            rf_wr_data_r   <= 64'd0;
            retire_valid_r <= 1'b0;
            retire_pc_r    <= 64'd0;
        end else if (pop_any_s) begin
            rf_wr_en_r     <= wb_writes_rf(sel_s);
            rf_wr_addr_r   <= sel_s.dst;
            rf_wr_data_r   <= sel_s.result;
            retire_valid_r <= 1'b1;
            retire_pc_r    <= sel_s.pc;
        end else begin
            rf_wr_en_r     <= 1'b0;
            retire_valid_r <= 1'b0;
        end
    end

    assign bus.wb_rf_wr_en     = rf_wr_en_r;
    assign bus.wb_rf_wr_addr   = rf_wr_addr_r;
    assign bus.wb_rf_wr_data   = rf_wr_data_r;
    assign bus.wb_retire_valid = retire_valid_r;
    assign bus.wb_retire_pc    = retire_pc_r;

`ifdef WB_ARBITER_RETIRE_CNT_EN
    logic [63:0] retire_cnt_r;

    // Counts retires, wrapping modulo 2^64.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_r <= 64'd0;
        end else if (pop_any_s) begin
            retire_cnt_r <= retire_cnt_r + 64'd1;
        end
    end

    assign bus.wb_retire_cnt = retire_cnt_r;
`else
    assign bus.wb_retire_cnt = 64'd0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (FIFO_DEPTH=2); builds with or
// without WB_ARBITER_RETIRE_CNT_EN.
module tb_wb_arbiter;

`ifdef WB_ARBITER_RETIRE_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   errs   = 0;
    int   checks = 0;
    int   ip_n, lp_n, ip_ret, lp_ret;
    logic acc_ip, acc_lp;

    wb_arbiter_if bus ();

    wb_arbiter #(.FIFO_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ip(input logic v, input logic [4:0] d, input logic [63:0] r,
                          input logic [63:0] p, input logic e);
        bus.ip_wb_valid  = v;
        bus.ip_wb_dst    = d;
        bus.ip_wb_result = r;
        bus.ip_wb_pc     = p;
        bus.ip_wb_wb_en  = e;
    endtask

    task automatic set_lp(input logic v, input logic [4:0] d, input logic [63:0] r,
                          input logic [63:0] p, input logic e);
        bus.lp_wb_valid  = v;
        bus.lp_wb_dst    = d;
        bus.lp_wb_result = r;
        bus.lp_wb_pc     = p;
        bus.lp_wb_wb_en  = e;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_ip(1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
        set_lp(1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_wr_en",     64'(bus.wb_rf_wr_en), 64'd0);
        chk("rst_wr_addr",   64'(bus.wb_rf_wr_addr), 64'd0);
        chk("rst_wr_data",   bus.wb_rf_wr_data, 64'd0);
        chk("rst_ret_valid", 64'(bus.wb_retire_valid), 64'd0);
        chk("rst_ret_pc",    bus.wb_retire_pc, 64'd0);
        chk("rst_cnt",       bus.wb_retire_cnt, 64'd0);
        tick();
        chk("rst_ip_ready",  64'(bus.ip_wb_ready), 64'd1);
        chk("rst_lp_ready",  64'(bus.lp_wb_ready), 64'd1);

        // Single ip beat: retire two edges after acceptance
        set_ip(1'b1, 5'd5, 64'h1234, 64'h8000_0000, 1'b1);
        tick();
        set_ip(1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
        chk("lat_early_valid", 64'(bus.wb_retire_valid), 64'd0);
        tick();
        chk("single_valid",  64'(bus.wb_retire_valid), 64'd1);
        chk("single_wr_en",  64'(bus.wb_rf_wr_en), 64'd1);
        chk("single_addr",   64'(bus.wb_rf_wr_addr), 64'd5);
        chk("single_data",   bus.wb_rf_wr_data, 64'h1234);
        chk("single_pc",     bus.wb_retire_pc, 64'h8000_0000);
        chk("single_cnt",    bus.wb_retire_cnt, CNT_ON ? 64'd1 : 64'd0);
        tick();
        chk("idle_valid",    64'(bus.wb_retire_valid), 64'd0);
        chk("idle_wr_en",    64'(bus.wb_rf_wr_en), 64'd0);
        chk("hold_addr",     64'(bus.wb_rf_wr_addr), 64'd5);
        chk("hold_data",     bus.wb_rf_wr_data, 64'h1234);

        // Two back-to-back simultaneous pairs: ip1, lp1, ip2, lp2
        do_reset();
        tick();
        set_ip(1'b1, 5'd1, 64'hA1, 64'h100, 1'b1);
        set_lp(1'b1, 5'd2, 64'hB1, 64'h200, 1'b1);
        tick();
        set_ip(1'b1, 5'd3, 64'hA2, 64'h104, 1'b1);
        set_lp(1'b1, 5'd4, 64'hB2, 64'h204, 1'b1);
        tick();
        set_ip(1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
        set_lp(1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
        chk("tie1_pc",   bus.wb_retire_pc, 64'h100);
        chk("tie1_data", bus.wb_rf_wr_data, 64'hA1);
        tick();
        chk("tie1b_pc",  bus.wb_retire_pc, 64'h200);
        chk("tie1b_addr", 64'(bus.wb_rf_wr_addr), 64'd2);
        tick();
        chk("tie2_pc",   bus.wb_retire_pc, 64'h104);
        tick();
        chk("tie2b_pc",  bus.wb_retire_pc, 64'h204);
        chk("tie2b_valid", 64'(bus.wb_retire_valid), 64'd1);
        tick();
        chk("tie_done_valid", 64'(bus.wb_retire_valid), 64'd0);

        // Retire without register write: dst=0, then wb_en=0
        set_lp(1'b1, 5'd0, 64'h55, 64'h300, 1'b1);
        tick();
        set_lp(1'b1, 5'd3, 64'h66, 64'h304, 1'b0);
        tick();
        set_lp(1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
        chk("x0_valid", 64'(bus.wb_retire_valid), 64'd1);
        chk("x0_wr_en", 64'(bus.wb_rf_wr_en), 64'd0);
        chk("x0_pc",    bus.wb_retire_pc, 64'h300);
        tick();
        chk("noen_valid", 64'(bus.wb_retire_valid), 64'd1);
        chk("noen_wr_en", 64'(bus.wb_rf_wr_en), 64'd0);
        chk("noen_addr",  64'(bus.wb_rf_wr_addr), 64'd3);
        chk("noen_pc",    bus.wb_retire_pc, 64'h304);
        tick();

        // Both sources streaming: backpressure, no loss, per-source order
        ip_n = 0; lp_n = 0; ip_ret = 0; lp_ret = 0;
        for (int k = 0; k < 16; k++) begin
            if (k < 10) begin
                set_ip(1'b1, 5'd7, 64'hA000 + 64'(ip_n), 64'h1000 + 64'(ip_n), 1'b1);
                set_lp(1'b1, 5'd9, 64'hB000 + 64'(lp_n), 64'h2000 + 64'(lp_n), 1'b1);
            end else begin
                set_ip(1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
                set_lp(1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
            end
            acc_ip = bus.ip_wb_valid && bus.ip_wb_ready;
            acc_lp = bus.lp_wb_valid && bus.lp_wb_ready;
            tick();
            if (acc_ip) ip_n++;
            if (acc_lp) lp_n++;
            if (k == 1) chk("lp_ready_full", 64'(bus.lp_wb_ready), 64'd0);
            if (k == 2) chk("ip_ready_full", 64'(bus.ip_wb_ready), 64'd0);
            if (bus.wb_retire_valid) begin
                if (bus.wb_retire_pc[15:12] == 4'h1) begin
                    chk("ip_order_pc",   bus.wb_retire_pc,  64'h1000 + 64'(ip_ret));
                    chk("ip_order_data", bus.wb_rf_wr_data, 64'hA000 + 64'(ip_ret));
                    ip_ret++;
                end else begin
                    chk("lp_order_pc",   bus.wb_retire_pc,  64'h2000 + 64'(lp_ret));
                    chk("lp_order_data", bus.wb_rf_wr_data, 64'hB000 + 64'(lp_ret));
                    lp_ret++;
                end
            end
        end
        chk("stream_accepted", 64'(ip_n + lp_n), 64'd12);
        chk("ip_no_loss",      64'(ip_ret), 64'(ip_n));
        chk("lp_no_loss",      64'(lp_ret), 64'(lp_n));

        // Reset with queues loaded: nothing retires on or after the reset edge
        for (int k = 0; k < 3; k++) begin
            set_ip(1'b1, 5'd11, 64'hDEAD, 64'h4000 + 64'(k), 1'b1);
            set_lp(1'b1, 5'd12, 64'hBEEF, 64'h5000 + 64'(k), 1'b1);
            tick();
        end
        rst = 1'b1;
        set_ip(1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
        set_lp(1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
        tick();
        chk("mid_rst_valid", 64'(bus.wb_retire_valid), 64'd0);
        chk("mid_rst_wr_en", 64'(bus.wb_rf_wr_en), 64'd0);
        chk("mid_rst_cnt",   bus.wb_retire_cnt, 64'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ip_ready", 64'(bus.ip_wb_ready), 64'd1);
        chk("post_rst_lp_ready", 64'(bus.lp_wb_ready), 64'd1);
        for (int k = 0; k < 4; k++) begin
            chk("no_stale_retire", 64'(bus.wb_retire_valid), 64'd0);
            tick();
        end

        // Counter wrap (or stays tied off)
`ifdef WB_ARBITER_RETIRE_CNT_EN
        force dut.retire_cnt_r = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.retire_cnt_r;
        chk("cnt_preset", bus.wb_retire_cnt, 64'hFFFF_FFFF_FFFF_FFFF);
`endif
        set_ip(1'b1, 5'd6, 64'h77, 64'h6000, 1'b1);
        tick();
        set_ip(1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
        tick();
        chk("wrap_valid", 64'(bus.wb_retire_valid), 64'd1);
        chk("wrap_cnt",   bus.wb_retire_cnt, 64'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
